// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the counter family
package counter_pkg;
  localparam int WRAPCNT_W = 16;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/mod_n_counter_if.sv
// mod_n_counter_if: control/status bundle of mod_n_counter
interface mod_n_counter_if #(parameter int WIDTH = 3);
  import counter_pkg::*;
  logic en, up_dn, sync_clr, load, term_wr, tc, wrap;
  logic [WIDTH-1:0] load_val, term_val, count, term;
  logic [WRAPCNT_W-1:0] wrap_cnt;
  modport master (
    output en, up_dn, sync_clr, load, load_val, term_wr, term_val,
    input  count, term, tc, wrap, wrap_cnt
  );
  modport slave (
    input  en, up_dn, sync_clr, load, load_val, term_wr, term_val,
    output count, term, tc, wrap, wrap_cnt
  );
endinterface

// File: rtl/term_shadow_reg.sv
// term_shadow_reg: shadow terminal value, applied to the active term only on apply events
module term_shadow_reg #(
  parameter int WIDTH = 3,
  parameter int TERM_INIT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             term_wr,
  input  logic [WIDTH-1:0] term_val,
  input  logic             apply,
  output logic [WIDTH-1:0] term
);
  logic [WIDTH-1:0] shadow, shadow_nx;
  logic pending, pending_nx;
  // a write landing on an apply cycle goes straight through to term
  assign shadow_nx = term_wr ? term_val : shadow;
  assign pending_nx = term_wr | pending;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shadow <= WIDTH'(TERM_INIT);
      pending <= 1'b0;
      term <= WIDTH'(TERM_INIT);
    end else begin
      shadow <= shadow_nx;
      pending <= pending_nx & ~apply;
      term <= (apply & pending_nx) ? shadow_nx : term;
    end
endmodule

// File: rtl/mod_n_counter.sv
// mod_n_counter: programmable modulo-N up/down counter with cascade outputs
// optional wrap event counter: `define MOD_COUNTER_WRAPCNT_EN
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int TERM_INIT = 5
) (
  input logic           clk,
  input logic           reset_n,
  mod_n_counter_if.slave bus
);
  logic [WIDTH-1:0] count, term;
  logic tc, apply, wrap;
  assign tc = bus.en & ~bus.sync_clr & ~bus.load &
              (bus.up_dn == DIR_UP ? count >= term : count == '0);
  assign apply = bus.sync_clr | bus.load | tc;
  term_shadow_reg #(.WIDTH(WIDTH), .TERM_INIT(TERM_INIT)) u_term (
    .clk      (clk),
    .reset_n  (reset_n),
    .term_wr  (bus.term_wr),
    .term_val (bus.term_val),
    .apply    (apply),
    .term     (term)
  );
  // tc already excludes clear/load, so it doubles as the wrap condition
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count <= '0;
      wrap <= 1'b0;
    end else begin
      count <= bus.sync_clr ? '0 :
               bus.load ? bus.load_val :
               !bus.en ? count :
               bus.up_dn == DIR_UP ? (tc ? '0 : count + 1'b1) :
               (tc ? term : count - 1'b1);
      wrap <= tc;
    end
`ifdef MOD_COUNTER_WRAPCNT_EN
  logic [WRAPCNT_W-1:0] wrap_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) wrap_cnt <= '0;
    else wrap_cnt <= bus.sync_clr ? '0 : (tc && wrap_cnt != '1) ? wrap_cnt + 1'b1 : wrap_cnt;
  assign bus.wrap_cnt = wrap_cnt;
`else
  assign bus.wrap_cnt = '0;
`endif
  assign bus.count = count;
  assign bus.term = term;
  assign bus.tc = tc;
  assign bus.wrap = wrap;
endmodule

// File: tb/tb_mod_n_counter.sv
// tb_mod_n_counter: scoreboard bench against a cycle model of the counter
module tb_mod_n_counter;
  import counter_pkg::*;
  localparam int W = 3;
  typedef struct {
    logic [W-1:0] count;
    logic [W-1:0] term;
    logic wrap;
    logic [15:0] wcnt;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  exp_t sbq[$];
  logic [W-1:0] m_count, m_term, m_shadow;
  logic m_pend;
  logic [15:0] m_wcnt;
  mod_n_counter_if #(.WIDTH(W)) bus ();
  mod_n_counter #(.WIDTH(W), .TERM_INIT(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;

  task automatic m_reset();
    m_count = '0;
    m_term = 3'd5;
    m_shadow = 3'd5;
    m_pend = 1'b0;
    m_wcnt = '0;
  endtask

  task automatic idle_inputs();
    bus.en = 0; bus.up_dn = DIR_UP; bus.sync_clr = 0; bus.load = 0;
    bus.load_val = '0; bus.term_wr = 0; bus.term_val = '0;
  endtask

  task automatic check_reset_outputs(input string nm);
    n_vec++;
    if (bus.count !== 3'd0 || bus.term !== 3'd5 || bus.wrap !== 1'b0 || bus.wrap_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL %s count=%0d term=%0d wrap=%b wrap_cnt=%0d, required 0/5/0/0",
               nm, bus.count, bus.term, bus.wrap, bus.wrap_cnt);
    end
  endtask

  task automatic step(input string nm, input logic e, input logic u, input logic c, input logic l,
                      input logic [W-1:0] lv, input logic tw, input logic [W-1:0] tv);
    exp_t x;
    logic tce;
    logic [W-1:0] nc, sh;
    bus.en = e; bus.up_dn = u; bus.sync_clr = c; bus.load = l;
    bus.load_val = lv; bus.term_wr = tw; bus.term_val = tv;
    #1;
    tce = e & ~c & ~l & (u ? m_count >= m_term : m_count == 0);
    n_vec++;
    if (bus.tc !== tce) begin
      n_err++;
      $display("FAIL %s tc=%b required %b (count=%0d)", nm, bus.tc, tce, m_count);
    end
    if (c) nc = '0;
    else if (l) nc = lv;
    else if (!e) nc = m_count;
    else if (u) nc = (m_count >= m_term) ? '0 : m_count + 1'b1;
    else nc = (m_count == 0) ? m_term : m_count - 1'b1;
    sh = tw ? tv : m_shadow;
    if ((c | l | tce) && (tw | m_pend)) begin
      m_term = sh;
      m_pend = 1'b0;
    end else m_pend = m_pend | tw;
    m_shadow = sh;
    m_count = nc;
`ifdef MOD_COUNTER_WRAPCNT_EN
    if (c) m_wcnt = '0;
    else if (tce && m_wcnt != 16'hFFFF) m_wcnt = m_wcnt + 1'b1;
`endif
    x.count = m_count; x.term = m_term; x.wrap = tce; x.wcnt = m_wcnt;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    n_vec += 4;
    if (bus.count !== x.count) begin n_err++; $display("FAIL %s count=%0d required %0d", nm, bus.count, x.count); end
    if (bus.term !== x.term) begin n_err++; $display("FAIL %s term=%0d required %0d", nm, bus.term, x.term); end
    if (bus.wrap !== x.wrap) begin n_err++; $display("FAIL %s wrap=%b required %b", nm, bus.wrap, x.wrap); end
    if (bus.wrap_cnt !== x.wcnt) begin n_err++; $display("FAIL %s wrap_cnt=%0d required %0d", nm, bus.wrap_cnt, x.wcnt); end
  endtask

  task automatic clr(input string nm);
    step(nm, 0, DIR_UP, 1, 0, '0, 0, '0);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    m_reset();
    #12;
    check_reset_outputs("reset");
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_up();
    for (int i = 0; i < 13; i++) step("up", 1, DIR_UP, 0, 0, '0, 0, '0);
    n_vec++;
    if (bus.count !== 3'd1) begin n_err++; $display("FAIL up_final count=%0d required 1", bus.count); end
  endtask

  task automatic test_down();
    clr("down_clr");
    for (int i = 0; i < 8; i++) step("down", 1, DIR_DN, 0, 0, '0, 0, '0);
    n_vec++;
    if (bus.count !== 3'd4) begin n_err++; $display("FAIL down_final count=%0d required 4", bus.count); end
  endtask

  task automatic test_shadow();
    clr("shadow_clr");
    step("shadow", 1, DIR_UP, 0, 0, '0, 0, '0);
    step("shadow_wr", 1, DIR_UP, 0, 0, '0, 1, 3'd2);
    for (int i = 0; i < 10; i++) step("shadow", 1, DIR_UP, 0, 0, '0, 0, '0);
    n_vec++;
    if (bus.term !== 3'd2 || bus.count !== 3'd0) begin
      n_err++; $display("FAIL shadow_final term=%0d count=%0d required 2/0", bus.term, bus.count);
    end
    step("shadow_restore", 0, DIR_UP, 1, 0, '0, 1, 3'd5);
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) step("prio_run", 1, DIR_UP, 0, 0, '0, 0, '0);
    step("prio_all", 1, DIR_UP, 1, 1, 3'd4, 0, '0);
    step("prio_ld_en", 1, DIR_UP, 0, 1, 3'd2, 0, '0);
    step("prio_ld7", 0, DIR_UP, 0, 1, 3'd7, 0, '0);
    step("prio_wrap", 1, DIR_UP, 0, 0, '0, 0, '0);
    step("prio_ld7b", 0, DIR_UP, 0, 1, 3'd7, 0, '0);
    step("prio_dn", 1, DIR_DN, 0, 0, '0, 0, '0);
  endtask

  task automatic test_async_reset();
    clr("async_clr");
    for (int i = 0; i < 3; i++) step("async_run", 1, DIR_UP, 0, 0, '0, 0, '0);
    step("async_wr", 0, DIR_UP, 0, 0, '0, 1, 3'd1);
    idle_inputs();
    #2 reset_n = 0;
    #1;
    m_reset();
    check_reset_outputs("async_reset");
    #1 reset_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) step("async_after", 1, DIR_UP, 0, 0, '0, 0, '0);
  endtask

  task automatic test_wrapcnt();
    step("wcnt_t0", 0, DIR_UP, 1, 0, '0, 1, 3'd0);
    for (int i = 0; i < 20; i++) step("wcnt_mod1", 1, i[0], 0, 0, '0, 0, '0);
    n_vec++;
`ifdef MOD_COUNTER_WRAPCNT_EN
    if (bus.wrap_cnt !== 16'd20) begin n_err++; $display("FAIL wcnt_20 wrap_cnt=%0d required 20", bus.wrap_cnt); end
`else
    if (bus.wrap_cnt !== 16'd0) begin n_err++; $display("FAIL wcnt_20 wrap_cnt=%0d required 0", bus.wrap_cnt); end
`endif
    step("wcnt_clr", 0, DIR_UP, 1, 0, '0, 1, 3'd5);
    n_vec++;
    if (bus.wrap_cnt !== 16'd0) begin n_err++; $display("FAIL wcnt_clr wrap_cnt=%0d required 0", bus.wrap_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(3) != 0, $urandom_range(1) != 0, $urandom_range(15) == 0,
           $urandom_range(9) == 0, W'($urandom), $urandom_range(7) == 0, W'($urandom));
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_shadow();
    test_priority();
    test_async_reset();
    test_wrapcnt();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
